xrf_wb: RTL and testbench

- Writeback stage directly upstream of the scalar register file (XRF); drives the XRF write port (rd, wdata, wen).
- Merges two result sources: single-cycle ALU results and variable-latency load returns. A 1-entry skid buffer absorbs ALU results that lose arbitration.
- Holds a 32-bit pending-load scoreboard and reports read-after-write hazards for the decode stage's rs1/rs2.

---
 rtl/xrf_wb_if.sv | 49 ++++
 rtl/xrf_wb.sv | 132 +++++++++++++
 tb/tb_xrf_wb.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/xrf_wb_if.sv
// Writeback-stage bundle: ALU result channel, load issue/return, decode hazard query, XRF write port.
// Bypass outputs exist only when XRF_WB_BYPASS_EN is defined.
interface xrf_wb_if #(
    parameter int unsigned XLEN = 32
);
    logic            i_alu_valid;
    logic            o_alu_ready;
    logic [4:0]      i_alu_rd;
    logic [XLEN-1:0] i_alu_data;
    logic            i_ld_issue;
    logic [4:0]      i_ld_issue_rd;
    logic            i_ld_valid;
    logic [4:0]      i_ld_rd;
    logic [XLEN-1:0] i_ld_data;
    logic [4:0]      i_rs1;
    logic [4:0]      i_rs2;
    logic            o_rs1_busy;
    logic            o_rs2_busy;
    logic [4:0]      o_rd;
    logic [XLEN-1:0] o_wdata;
    logic            o_wen;
    logic            o_idle;
`ifdef XRF_WB_BYPASS_EN
    logic            o_rs1_fwd;
    logic            o_rs2_fwd;
    logic [XLEN-1:0] o_fwd_data1;
    logic [XLEN-1:0] o_fwd_data2;
`endif

    modport master (
        output i_alu_valid, i_alu_rd, i_alu_data,
        output i_ld_issue, i_ld_issue_rd, i_ld_valid, i_ld_rd, i_ld_data,
        output i_rs1, i_rs2,
`ifdef XRF_WB_BYPASS_EN
        input  o_rs1_fwd, o_rs2_fwd, o_fwd_data1, o_fwd_data2,
`endif
        input  o_alu_ready, o_rs1_busy, o_rs2_busy, o_rd, o_wdata, o_wen, o_idle
    );

    modport slave (
        input  i_alu_valid, i_alu_rd, i_alu_data,
        input  i_ld_issue, i_ld_issue_rd, i_ld_valid, i_ld_rd, i_ld_data,
        input  i_rs1, i_rs2,
`ifdef XRF_WB_BYPASS_EN
        output o_rs1_fwd, o_rs2_fwd, o_fwd_data1, o_fwd_data2,
`endif
        output o_alu_ready, o_rs1_busy, o_rs2_busy, o_rd, o_wdata, o_wen, o_idle
    );
endinterface

// File: rtl/xrf_wb.sv
// XRF writeback: arbitrates load returns, a 1-entry ALU skid and new ALU results onto the XRF
// write port, and tracks pending loads for RAW hazards. Optional forwarding: XRF_WB_BYPASS_EN.
module xrf_wb #(
    parameter int unsigned XLEN = 32
) (
    input logic     i_clk,
    input logic     i_rst,
    xrf_wb_if.slave bus
);
    logic            skid_valid_q, skid_valid_d;
    logic [4:0]      skid_rd_q, skid_rd_d;
    logic [XLEN-1:0] skid_data_q, skid_data_d;
    logic [31:0]     busy_q, busy_d;
    logic [4:0]      rd_q, rd_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic            wen_q, wen_d;

    logic            alu_acc;
    logic            sel_valid;
    logic            sel_alu;
    logic [4:0]      sel_rd;
    logic [XLEN-1:0] sel_data;
    logic            out_hit1, out_hit2;

    assign alu_acc = bus.i_alu_valid && !skid_valid_q;

    always_comb begin
        sel_valid = 1'b0;
        sel_alu   = 1'b0;
        sel_rd    = '0;
        sel_data  = '0;
        if (bus.i_ld_valid) begin
            sel_valid = 1'b1;
            sel_rd    = bus.i_ld_rd;
            sel_data  = bus.i_ld_data;
        end else if (skid_valid_q) begin
            sel_valid = 1'b1;
            sel_rd    = skid_rd_q;
            sel_data  = skid_data_q;
        end else if (alu_acc) begin
            sel_valid = 1'b1;
            sel_alu   = 1'b1;
            sel_rd    = bus.i_alu_rd;
            sel_data  = bus.i_alu_data;
        end
    end

    always_comb begin
        skid_valid_d = skid_valid_q;
        skid_rd_d    = skid_rd_q;
        skid_data_d  = skid_data_q;
        // Skid drains whenever no load return pre-empts it.
        if (skid_valid_q && !bus.i_ld_valid) begin
            skid_valid_d = 1'b0;
        end
        if (alu_acc && !sel_alu) begin
            skid_valid_d = 1'b1;
            skid_rd_d    = bus.i_alu_rd;
            skid_data_d  = bus.i_alu_data;
        end
    end

    always_comb begin
        rd_d    = rd_q;
        wdata_d = wdata_q;
        wen_d   = 1'b0;
        if (sel_valid && (sel_rd != 5'd0)) begin
            wen_d   = 1'b1;
            rd_d    = sel_rd;
            wdata_d = sel_data;
        end
    end

    always_comb begin
        busy_d = busy_q;
        if (bus.i_ld_valid && (bus.i_ld_rd != 5'd0)) begin
            busy_d[bus.i_ld_rd] = 1'b0;
        end
        // Applied after the clear so a same-cycle reissue stays outstanding.
        if (bus.i_ld_issue && (bus.i_ld_issue_rd != 5'd0)) begin
            busy_d[bus.i_ld_issue_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            skid_valid_q <= 1'b0;
            skid_rd_q    <= '0;
            skid_data_q  <= '0;
            busy_q       <= '0;
            rd_q         <= '0;
            wdata_q      <= '0;
            wen_q        <= 1'b0;
        end else begin
            skid_valid_q <= skid_valid_d;
            skid_rd_q    <= skid_rd_d;
            skid_data_q  <= skid_data_d;
            busy_q       <= busy_d;
            rd_q         <= rd_d;
            wdata_q      <= wdata_d;
            wen_q        <= wen_d;
        end
    end

    assign out_hit1 = wen_q && (rd_q == bus.i_rs1) && (bus.i_rs1 != 5'd0);
    assign out_hit2 = wen_q && (rd_q == bus.i_rs2) && (bus.i_rs2 != 5'd0);

    logic pend1, pend2;
    assign pend1 = (bus.i_rs1 != 5'd0) &&
                   (busy_q[bus.i_rs1] || (skid_valid_q && (skid_rd_q == bus.i_rs1)));
    assign pend2 = (bus.i_rs2 != 5'd0) &&
                   (busy_q[bus.i_rs2] || (skid_valid_q && (skid_rd_q == bus.i_rs2)));

`ifdef XRF_WB_BYPASS_EN
    assign bus.o_rs1_busy  = pend1;
    assign bus.o_rs2_busy  = pend2;
    assign bus.o_rs1_fwd   = out_hit1;
    assign bus.o_rs2_fwd   = out_hit2;
    assign bus.o_fwd_data1 = wdata_q;
    assign bus.o_fwd_data2 = wdata_q;
`else
    assign bus.o_rs1_busy  = pend1 || out_hit1;
    assign bus.o_rs2_busy  = pend2 || out_hit2;
`endif

    assign bus.o_alu_ready = !skid_valid_q;
    assign bus.o_rd        = rd_q;
    assign bus.o_wdata     = wdata_q;
    assign bus.o_wen       = wen_q;
    assign bus.o_idle      = (busy_q == 32'd0) && !skid_valid_q && !wen_q;
endmodule

// File: tb/tb_xrf_wb.sv
// Directed bench for xrf_wb: arbitration, skid stall, scoreboard, rd==0 and async reset.
module tb_xrf_wb;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_pass = 0;

    xrf_wb_if #(.XLEN(32)) bus ();

    xrf_wb #(.XLEN(32)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.i_alu_valid   = 1'b0;
        bus.i_alu_rd      = '0;
        bus.i_alu_data    = '0;
        bus.i_ld_issue    = 1'b0;
        bus.i_ld_issue_rd = '0;
        bus.i_ld_valid    = 1'b0;
        bus.i_ld_rd       = '0;
        bus.i_ld_data     = '0;
    endtask

    task automatic check_write(input string tag, input logic [4:0] rd, input logic [31:0] d);
        check({tag, "_wen"}, 32'(bus.o_wen), 32'd1);
        check({tag, "_rd"}, 32'(bus.o_rd), 32'(rd));
        check({tag, "_wdata"}, bus.o_wdata, d);
    endtask

    initial begin
        idle_inputs();
        bus.i_rs1 = '0;
        bus.i_rs2 = '0;
        repeat (2) tick();
        check("rst_wen", 32'(bus.o_wen), 32'd0);
        check("rst_rd", 32'(bus.o_rd), 32'd0);
        check("rst_wdata", bus.o_wdata, 32'd0);
        check("rst_ready", 32'(bus.o_alu_ready), 32'd1);
        check("rst_idle", 32'(bus.o_idle), 32'd1);
        rst = 1'b0;
        tick();

        // ALU only
        bus.i_alu_valid = 1'b1; bus.i_alu_rd = 5'd5; bus.i_alu_data = 32'hDEADBEEF;
        tick();
        idle_inputs();
        bus.i_rs1 = 5'd5;
        #1;
        check_write("alu", 5'd5, 32'hDEADBEEF);
        check("alu_ready", 32'(bus.o_alu_ready), 32'd1);
        check("alu_idle", 32'(bus.o_idle), 32'd0);
`ifdef XRF_WB_BYPASS_EN
        check("alu_rs1_busy", 32'(bus.o_rs1_busy), 32'd0);
        check("alu_rs1_fwd", 32'(bus.o_rs1_fwd), 32'd1);
        check("alu_fwd_data1", bus.o_fwd_data1, 32'hDEADBEEF);
`else
        check("alu_rs1_busy", 32'(bus.o_rs1_busy), 32'd1);
`endif
        tick();
        check("alu_wen_drop", 32'(bus.o_wen), 32'd0);

        // Collision: load wins, ALU goes to skid
        bus.i_ld_valid = 1'b1; bus.i_ld_rd = 5'd3; bus.i_ld_data = 32'h11;
        bus.i_alu_valid = 1'b1; bus.i_alu_rd = 5'd4; bus.i_alu_data = 32'h22;
        tick();
        idle_inputs();
        bus.i_rs2 = 5'd4;
        #1;
        check_write("col_ld", 5'd3, 32'h11);
        check("col_ready0", 32'(bus.o_alu_ready), 32'd0);
        check("col_rs2_skid_busy", 32'(bus.o_rs2_busy), 32'd1);
        check("col_idle0", 32'(bus.o_idle), 32'd0);
        tick();
        check_write("col_alu", 5'd4, 32'h22);
        check("col_ready1", 32'(bus.o_alu_ready), 32'd1);
        tick();
        check("col_idle1", 32'(bus.o_idle), 32'd1);

        // Skid held across a second load, then stalled ALU admitted
        bus.i_ld_valid = 1'b1; bus.i_ld_rd = 5'd3; bus.i_ld_data = 32'h31;
        bus.i_alu_valid = 1'b1; bus.i_alu_rd = 5'd4; bus.i_alu_data = 32'h41;
        tick();
        bus.i_ld_rd = 5'd8; bus.i_ld_data = 32'h81;
        bus.i_alu_rd = 5'd6; bus.i_alu_data = 32'h61;
        #1;
        check("hold_ready", 32'(bus.o_alu_ready), 32'd0);
        tick();
        bus.i_ld_valid = 1'b0; bus.i_ld_rd = '0; bus.i_ld_data = '0;
        check_write("hold_ld", 5'd8, 32'h81);
        check("hold_ready2", 32'(bus.o_alu_ready), 32'd0);
        tick();
        check_write("hold_skid", 5'd4, 32'h41);
        tick();
        idle_inputs();
        check_write("hold_alu", 5'd6, 32'h61);
        tick();

        // Scoreboard
        bus.i_ld_issue = 1'b1; bus.i_ld_issue_rd = 5'd7; bus.i_rs1 = 5'd7;
        tick();
        idle_inputs();
        check("sb_busy", 32'(bus.o_rs1_busy), 32'd1);
        check("sb_idle", 32'(bus.o_idle), 32'd0);
        repeat (2) tick();
        check("sb_busy_hold", 32'(bus.o_rs1_busy), 32'd1);
        bus.i_ld_valid = 1'b1; bus.i_ld_rd = 5'd7; bus.i_ld_data = 32'h55;
        tick();
        idle_inputs();
        #1;
        check_write("sb_ret", 5'd7, 32'h55);
`ifdef XRF_WB_BYPASS_EN
        check("sb_busy_wb", 32'(bus.o_rs1_busy), 32'd0);
        check("sb_fwd", 32'(bus.o_rs1_fwd), 32'd1);
        check("sb_fwd_data", bus.o_fwd_data1, 32'h55);
`else
        check("sb_busy_wb", 32'(bus.o_rs1_busy), 32'd1);
`endif
        tick();
        check("sb_busy_clr", 32'(bus.o_rs1_busy), 32'd0);
        check("sb_idle_clr", 32'(bus.o_idle), 32'd1);

        // Same-cycle issue and return of rd 9
        bus.i_ld_issue = 1'b1; bus.i_ld_issue_rd = 5'd9;
        bus.i_ld_valid = 1'b1; bus.i_ld_rd = 5'd9; bus.i_ld_data = 32'h99;
        bus.i_rs1 = 5'd9;
        tick();
        idle_inputs();
        check_write("same", 5'd9, 32'h99);
        tick();
        check("same_busy", 32'(bus.o_rs1_busy), 32'd1);
        check("same_idle", 32'(bus.o_idle), 32'd0);

        // rd==0 result: no write, outputs hold
        bus.i_alu_valid = 1'b1; bus.i_alu_rd = 5'd0; bus.i_alu_data = 32'hFFFF;
        bus.i_rs1 = 5'd0; bus.i_rs2 = 5'd9;
        tick();
        idle_inputs();
        check("rd0_wen", 32'(bus.o_wen), 32'd0);
        check("rd0_rd_hold", 32'(bus.o_rd), 32'd9);
        check("rd0_wdata_hold", bus.o_wdata, 32'h99);
        check("rs0_not_busy", 32'(bus.o_rs1_busy), 32'd0);
        check("rs2_busy9", 32'(bus.o_rs2_busy), 32'd1);

        // Async reset with skid full and busy[2]
        bus.i_ld_issue = 1'b1; bus.i_ld_issue_rd = 5'd2;
        bus.i_ld_valid = 1'b1; bus.i_ld_rd = 5'd3; bus.i_ld_data = 32'h33;
        bus.i_alu_valid = 1'b1; bus.i_alu_rd = 5'd6; bus.i_alu_data = 32'h66;
        tick();
        idle_inputs();
        bus.i_rs1 = 5'd2;
        #1;
        check("pre_rst_ready", 32'(bus.o_alu_ready), 32'd0);
        check("pre_rst_busy2", 32'(bus.o_rs1_busy), 32'd1);
        rst = 1'b1;
        #1;
        check("arst_wen", 32'(bus.o_wen), 32'd0);
        check("arst_rd", 32'(bus.o_rd), 32'd0);
        check("arst_wdata", bus.o_wdata, 32'd0);
        check("arst_ready", 32'(bus.o_alu_ready), 32'd1);
        check("arst_busy2", 32'(bus.o_rs1_busy), 32'd0);
        check("arst_idle", 32'(bus.o_idle), 32'd1);
        tick();
        rst = 1'b0;
        tick();
        check("post_rst_wen", 32'(bus.o_wen), 32'd0);
        check("post_rst_ready", 32'(bus.o_alu_ready), 32'd1);
        check("post_rst_idle", 32'(bus.o_idle), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
